// File: rtl/usb_buf_pkg.sv
// Shared types and helpers for the multi-endpoint USB data buffer.
package usb_buf_pkg;

    typedef logic [7:0] usb_byte_t;

    // Width of an endpoint select; never narrower than one bit.
    function automatic int unsigned ep_w(input int unsigned num_ep);
        return (num_ep > 1) ? $clog2(num_ep) : 1;
    endfunction

endpackage

// File: rtl/usb_ep_fifo.sv
// Single-endpoint circular byte FIFO with fall-through head and clear.
module usb_ep_fifo
    import usb_buf_pkg::*;
#(
    parameter int unsigned DEPTH = 64,
    localparam int unsigned OCC_W = $clog2(DEPTH + 1),
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             push,
    input  logic             pop,
    input  usb_byte_t        din,
    input  logic             clr,
    output usb_byte_t        dout,
    output logic [OCC_W-1:0] count,
    output logic             full,
    output logic             empty
);

    usb_byte_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] count_q, count_d;
    logic             pop_ok;
    logic             push_ok;
    logic             wr_en;

    assign empty = (count_q == '0);
    assign full  = (count_q == OCC_W'(DEPTH));
    assign count = count_q;
    assign dout  = empty ? 8'h00 : mem_q[rd_ptr_q];

    // Accept pop when data exists; a same-cycle pop frees a slot for a push at full.
    always_comb begin
        pop_ok   = pop && !empty;
        push_ok  = push && (!full || pop_ok);
        wr_en    = push_ok && !clr;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + OCC_W'(1);
                2'b01:   count_d = count_q - OCC_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Byte storage; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/usb_ep_data_buffer.sv
// Multi-endpoint USB data buffer: per-EP FIFOs shared by the USB engines and the AHB side.
module usb_ep_data_buffer
    import usb_buf_pkg::*;
#(
    parameter int unsigned NUM_EP = 4,
    parameter int unsigned DEPTH  = 64,
    localparam int unsigned OCC_W = $clog2(DEPTH + 1),
    localparam int unsigned EPW   = ep_w(NUM_EP)
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic [EPW-1:0]          usb_ep,
    input  logic                    store_rx_packet_data,
    input  logic [7:0]              rx_packet_data,
    input  logic                    get_tx_packet_data,
    output logic [7:0]              tx_packet_data,
    input  logic                    flush,
    input  logic [EPW-1:0]          ahb_ep,
    input  logic                    store_tx_data,
    input  logic [7:0]              tx_data,
    input  logic                    get_rx_data,
    output logic [7:0]              rx_data,
    input  logic                    clear,
    output logic [OCC_W-1:0]        buffer_occupancy,
    output logic [OCC_W-1:0]        ahb_occupancy,
    output logic [NUM_EP*OCC_W-1:0] ep_occupancy,
    output logic                    overflow,
    output logic                    underflow
);

    logic [NUM_EP-1:0] push_v, pop_v, clr_v, full_v, empty_v;
    usb_byte_t         din_v   [NUM_EP];
    usb_byte_t         dout_v  [NUM_EP];
    logic [OCC_W-1:0]  count_v [NUM_EP];
    logic              usb_vld, ahb_vld;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;

    assign usb_vld   = (32'(usb_ep) < NUM_EP);
    assign ahb_vld   = (32'(ahb_ep) < NUM_EP);
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

    // Decode selects, arbitrate same-EP collisions (USB side wins) and derive error pulses.
    always_comb begin
        logic u_hit, a_hit, u_push, a_push, u_pop, a_pop, pop_ok;
        push_v      = '0;
        pop_v       = '0;
        clr_v       = '0;
        overflow_d  = (store_rx_packet_data && !usb_vld) || (store_tx_data && !ahb_vld);
        underflow_d = (get_tx_packet_data && !usb_vld) || (get_rx_data && !ahb_vld);
        for (int unsigned e = 0; e < NUM_EP; e++) begin
            u_hit     = usb_vld && (usb_ep == EPW'(e));
            a_hit     = ahb_vld && (ahb_ep == EPW'(e));
            u_push    = store_rx_packet_data && u_hit;
            a_push    = store_tx_data && a_hit;
            u_pop     = get_tx_packet_data && u_hit;
            a_pop     = get_rx_data && a_hit;
            clr_v[e]  = (flush && u_hit) || (clear && a_hit);
            push_v[e] = !clr_v[e] && (u_push || a_push);
            pop_v[e]  = !clr_v[e] && (u_pop || a_pop);
            din_v[e]  = u_push ? rx_packet_data : tx_data;
            pop_ok    = pop_v[e] && !empty_v[e];
            if (!clr_v[e]) begin
                if ((u_push && a_push) || (push_v[e] && full_v[e] && !pop_ok)) overflow_d = 1'b1;
                if ((u_pop && a_pop) || (pop_v[e] && empty_v[e]))              underflow_d = 1'b1;
            end
        end
    end

    // One FIFO per endpoint.
    for (genvar g = 0; g < NUM_EP; g++) begin : g_ep
        usb_ep_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clk   (clk),
            .n_rst (n_rst),
            .push  (push_v[g]),
            .pop   (pop_v[g]),
            .din   (din_v[g]),
            .clr   (clr_v[g]),
            .dout  (dout_v[g]),
            .count (count_v[g]),
            .full  (full_v[g]),
            .empty (empty_v[g])
        );
    end

    // Route head bytes and registered counts of the selected endpoints.
    always_comb begin
        tx_packet_data   = 8'h00;
        rx_data          = 8'h00;
        buffer_occupancy = '0;
        ahb_occupancy    = '0;
        ep_occupancy     = '0;
        for (int unsigned e = 0; e < NUM_EP; e++) begin
            if (usb_vld && (usb_ep == EPW'(e))) begin
                tx_packet_data   = dout_v[e];
                buffer_occupancy = count_v[e];
            end
            if (ahb_vld && (ahb_ep == EPW'(e))) begin
                rx_data       = dout_v[e];
                ahb_occupancy = count_v[e];
            end
            ep_occupancy[e*OCC_W +: OCC_W] = count_v[e];
        end
    end

    // Single-cycle error pulse registers.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

endmodule

// File: tb/tb_usb_ep_data_buffer.sv
// Self-checking bench for usb_ep_data_buffer: queue-level model plus directed vectors.
module tb_usb_ep_data_buffer;

    localparam int unsigned NUM_EP = 4;
    localparam int unsigned DEPTH  = 64;
    localparam int unsigned OCC_W  = 7;
    localparam int unsigned EPW    = 2;

    logic                    clk = 1'b0;
    logic                    n_rst;
    logic [EPW-1:0]          usb_ep, ahb_ep;
    logic                    store_rx_packet_data, get_tx_packet_data, flush;
    logic                    store_tx_data, get_rx_data, clear;
    logic [7:0]              rx_packet_data, tx_data;
    logic [7:0]              tx_packet_data, rx_data;
    logic [OCC_W-1:0]        buffer_occupancy, ahb_occupancy;
    logic [NUM_EP*OCC_W-1:0] ep_occupancy;
    logic                    overflow, underflow;

    always #5 clk = ~clk;

    usb_ep_data_buffer #(.NUM_EP(NUM_EP), .DEPTH(DEPTH)) dut (
        .clk                  (clk),
        .n_rst                (n_rst),
        .usb_ep               (usb_ep),
        .store_rx_packet_data (store_rx_packet_data),
        .rx_packet_data       (rx_packet_data),
        .get_tx_packet_data   (get_tx_packet_data),
        .tx_packet_data       (tx_packet_data),
        .flush                (flush),
        .ahb_ep               (ahb_ep),
        .store_tx_data        (store_tx_data),
        .tx_data              (tx_data),
        .get_rx_data          (get_rx_data),
        .rx_data              (rx_data),
        .clear                (clear),
        .buffer_occupancy     (buffer_occupancy),
        .ahb_occupancy        (ahb_occupancy),
        .ep_occupancy         (ep_occupancy),
        .overflow             (overflow),
        .underflow            (underflow)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each endpoint is a byte ring (storage, head index, fill count).
    logic [7:0] m_mem [NUM_EP][DEPTH];
    int         m_head [NUM_EP];
    int         m_cnt  [NUM_EP];
    logic       m_ovf = 1'b0;
    logic       m_und = 1'b0;

    initial begin
        for (int e = 0; e < NUM_EP; e++) begin
            m_head[e] = 0;
            m_cnt[e]  = 0;
        end
    end

    always @(posedge clk) begin : model
        bit         u_ok, a_ok, ovf, und;
        bit         clr_ep   [NUM_EP];
        bit         push_req [NUM_EP];
        bit         pop_req  [NUM_EP];
        logic [7:0] push_byte [NUM_EP];
        if (!n_rst) begin
            for (int e = 0; e < NUM_EP; e++) begin
                m_cnt[e]  = 0;
                m_head[e] = 0;
            end
            m_ovf = 1'b0;
            m_und = 1'b0;
        end else begin
            u_ok = 32'(usb_ep) < NUM_EP;
            a_ok = 32'(ahb_ep) < NUM_EP;
            ovf  = 1'b0;
            und  = 1'b0;
            for (int e = 0; e < NUM_EP; e++) begin
                clr_ep[e]    = (flush && u_ok && 32'(usb_ep) == e) || (clear && a_ok && 32'(ahb_ep) == e);
                push_req[e]  = 1'b0;
                pop_req[e]   = 1'b0;
                push_byte[e] = 8'h00;
            end
            if (store_rx_packet_data) begin
                if (!u_ok) ovf = 1'b1;
                else if (!clr_ep[usb_ep]) begin
                    push_req[usb_ep]  = 1'b1;
                    push_byte[usb_ep] = rx_packet_data;
                end
            end
            if (store_tx_data) begin
                if (!a_ok) ovf = 1'b1;
                else if (!clr_ep[ahb_ep]) begin
                    if (push_req[ahb_ep]) ovf = 1'b1;
                    else begin
                        push_req[ahb_ep]  = 1'b1;
                        push_byte[ahb_ep] = tx_data;
                    end
                end
            end
            if (get_tx_packet_data) begin
                if (!u_ok) und = 1'b1;
                else if (!clr_ep[usb_ep]) pop_req[usb_ep] = 1'b1;
            end
            if (get_rx_data) begin
                if (!a_ok) und = 1'b1;
                else if (!clr_ep[ahb_ep]) begin
                    if (pop_req[ahb_ep]) und = 1'b1;
                    else pop_req[ahb_ep] = 1'b1;
                end
            end
            for (int e = 0; e < NUM_EP; e++) begin
                if (clr_ep[e]) begin
                    m_cnt[e]  = 0;
                    m_head[e] = 0;
                end else begin
                    if (pop_req[e]) begin
                        if (m_cnt[e] > 0) begin
                            m_head[e] = (m_head[e] + 1) % DEPTH;
                            m_cnt[e]--;
                        end else und = 1'b1;
                    end
                    if (push_req[e]) begin
                        if (m_cnt[e] < DEPTH) begin
                            m_mem[e][(m_head[e] + m_cnt[e]) % DEPTH] = push_byte[e];
                            m_cnt[e]++;
                        end else ovf = 1'b1;
                    end
                end
            end
            m_ovf = ovf;
            m_und = und;
        end
    end

    function automatic logic [7:0] exp_head(input logic [EPW-1:0] ep);
        if (32'(ep) >= NUM_EP || m_cnt[ep] == 0) return 8'h00;
        return m_mem[ep][m_head[ep]];
    endfunction

    function automatic logic [OCC_W-1:0] exp_occ(input logic [EPW-1:0] ep);
        if (32'(ep) >= NUM_EP) return '0;
        return OCC_W'(m_cnt[ep]);
    endfunction

    // Compare all outputs against the model in the middle of every cycle.
    always @(negedge clk) begin
        logic [NUM_EP*OCC_W-1:0] occ_all;
        if (chk_en) begin
            occ_all = '0;
            for (int e = 0; e < NUM_EP; e++) occ_all[e*OCC_W +: OCC_W] = OCC_W'(m_cnt[e]);
            check("tx_packet_data",   32'(tx_packet_data),   32'(exp_head(usb_ep)));
            check("rx_data",          32'(rx_data),          32'(exp_head(ahb_ep)));
            check("buffer_occupancy", 32'(buffer_occupancy), 32'(exp_occ(usb_ep)));
            check("ahb_occupancy",    32'(ahb_occupancy),    32'(exp_occ(ahb_ep)));
            check("ep_occupancy",     32'(ep_occupancy),     32'(occ_all));
            check("overflow",         32'(overflow),         32'(m_ovf));
            check("underflow",        32'(underflow),        32'(m_und));
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic idle();
        store_rx_packet_data = 1'b0;
        get_tx_packet_data   = 1'b0;
        flush                = 1'b0;
        store_tx_data        = 1'b0;
        get_rx_data          = 1'b0;
        clear                = 1'b0;
    endtask

    initial begin
        n_rst          = 1'b0;
        usb_ep         = '0;
        ahb_ep         = '0;
        rx_packet_data = 8'h00;
        tx_data        = 8'h00;
        idle();
        tick(2);
        chk_en = 1'b1;
        check("rst_occ", 32'(buffer_occupancy), 32'd0);
        check("rst_tx",  32'(tx_packet_data),   32'h00);
        check("rst_ovf", 32'(overflow),         32'd0);
        n_rst = 1'b1;

        // USB-side pushes to EP1, CPU-side drains in order.
        usb_ep = 2'd1;
        for (int i = 0; i < 4; i++) begin
            rx_packet_data       = 8'(8'h11 + i);
            store_rx_packet_data = 1'b1;
            tick();
        end
        idle();
        check("ep1_occ4", 32'(buffer_occupancy), 32'd4);
        ahb_ep = 2'd1;
        #1;
        check("ep1_head", 32'(rx_data), 32'h11);
        for (int i = 0; i < 4; i++) begin
            check("ep1_pop_byte", 32'(rx_data), 32'(8'h11 + i));
            get_rx_data = 1'b1;
            tick();
        end
        idle();
        check("ep1_drained", 32'(ahb_occupancy), 32'd0);

        // Fill EP0 to DEPTH, overflow, then rotate through a wrap at full.
        ahb_ep = 2'd0;
        for (int i = 0; i < DEPTH; i++) begin
            tx_data       = 8'(i);
            store_tx_data = 1'b1;
            tick();
        end
        tx_data = 8'hEE;
        tick();
        idle();
        check("full_ovf",   32'(overflow),      32'd1);
        check("full_occ",   32'(ahb_occupancy), 32'd64);
        tick();
        check("ovf_pulse1", 32'(overflow),      32'd0);
        check("full_head",  32'(rx_data),       32'h00);
        for (int i = 0; i < 70; i++) begin
            tx_data       = 8'(8'h80 + i);
            store_tx_data = 1'b1;
            get_rx_data   = 1'b1;
            tick();
        end
        idle();
        check("wrap_occ",  32'(ahb_occupancy), 32'd64);
        check("wrap_head", 32'(rx_data),       32'h86);
        get_rx_data = 1'b1;
        tick(DEPTH);
        idle();
        check("ep0_drained", 32'(ahb_occupancy), 32'd0);

        // Underflow on empty EP2, then push+pop on empty.
        ahb_ep      = 2'd2;
        get_rx_data = 1'b1;
        tick();
        idle();
        check("und_pulse", 32'(underflow),     32'd1);
        check("und_data",  32'(rx_data),       32'h00);
        check("und_occ",   32'(ahb_occupancy), 32'd0);
        tx_data       = 8'h33;
        store_tx_data = 1'b1;
        get_rx_data   = 1'b1;
        tick();
        idle();
        check("pp_empty_occ", 32'(ahb_occupancy), 32'd1);
        check("pp_empty_und", 32'(underflow),     32'd1);
        check("pp_empty_hd",  32'(rx_data),       32'h33);
        clear = 1'b1;
        tick();
        idle();

        // Independent concurrent traffic on EP0 (USB push) and EP3 (CPU pop).
        ahb_ep = 2'd3;
        for (int i = 0; i < 32; i++) begin
            tx_data       = 8'(8'h40 + i);
            store_tx_data = 1'b1;
            tick();
        end
        idle();
        usb_ep = 2'd0;
        for (int i = 0; i < 32; i++) begin
            rx_packet_data       = 8'(i);
            store_rx_packet_data = 1'b1;
            get_rx_data          = 1'b1;
            tick();
        end
        idle();
        check("conc_occ", 32'(ep_occupancy), 32'd32);
        check("conc_ovf", 32'(overflow),     32'd0);
        check("conc_und", 32'(underflow),    32'd0);
        flush = 1'b1;
        tick();
        idle();
        check("flush_ep0", 32'(buffer_occupancy), 32'd0);

        // Same-EP double push, then flush beating a same-cycle push.
        usb_ep               = 2'd1;
        ahb_ep               = 2'd1;
        rx_packet_data       = 8'hAA;
        tx_data              = 8'h55;
        store_rx_packet_data = 1'b1;
        store_tx_data        = 1'b1;
        tick();
        idle();
        check("dpush_ovf",  32'(overflow),         32'd1);
        check("dpush_occ",  32'(buffer_occupancy), 32'd1);
        check("dpush_byte", 32'(tx_packet_data),   32'hAA);
        rx_packet_data       = 8'h77;
        flush                = 1'b1;
        store_rx_packet_data = 1'b1;
        tick();
        idle();
        check("flush_push_occ", 32'(buffer_occupancy), 32'd0);
        check("flush_push_ovf", 32'(overflow),         32'd0);

        // Fill every EP to 10, then reset in the middle of traffic.
        usb_ep = 2'd0;
        ahb_ep = 2'd1;
        for (int i = 0; i < 10; i++) begin
            rx_packet_data       = 8'(8'hA0 + i);
            tx_data              = 8'(8'hB0 + i);
            store_rx_packet_data = 1'b1;
            store_tx_data        = 1'b1;
            tick();
        end
        usb_ep = 2'd2;
        ahb_ep = 2'd3;
        for (int i = 0; i < 10; i++) begin
            rx_packet_data = 8'(8'hC0 + i);
            tx_data        = 8'(8'hD0 + i);
            tick();
        end
        check("all10_occ", 32'(ep_occupancy), 32'({4{7'd10}}));
        n_rst = 1'b0;
        tick();
        n_rst = 1'b1;
        idle();
        check("mid_rst_occ", 32'(ep_occupancy),   32'd0);
        check("mid_rst_tx",  32'(tx_packet_data), 32'h00);
        check("mid_rst_rx",  32'(rx_data),        32'h00);
        check("mid_rst_ovf", 32'(overflow),       32'd0);
        check("mid_rst_und", 32'(underflow),      32'd0);
        tick(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
